// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-frame ghost rejection, debounce,
// hex key encoding and a valid/ready event port. Auto-repeat is built in only when the macro KEYPAD_TYPEMATIC_EN is defined.
module keypad_scanner #(
  parameter int SCAN_RATE       = 18,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_overrun,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  state_e               state_q;
  logic [3:0]           rows_meta_q, rows_sync_q;
  logic [SCAN_RATE-1:0] scan_cnt_q;
  logic [1:0]           col_idx_q;
  logic [3:0]           cols_q;
  logic [1:0]           hits_q, hits_d;
  logic [3:0]           hit_code_q, hit_code_d;
  logic [3:0]           cand_q, cnt_q, rcnt_q;
  logic                 held_q;
  logic                 valid_q, overrun_q;
  logic [3:0]           code_q;
  logic                 tick, frame_end, frame_key, ev;
  logic [3:0]           frame_code;
  logic [2:0]           row_cnt;
  logic [1:0]           row_idx;

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_cnt_q;
`endif

  assign tick        = &scan_cnt_q;
  assign frame_end   = tick && (col_idx_q == 2'd3);
  assign cols        = cols_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_overrun = overrun_q;
  assign dbg_state_o = state_q;

  // Frame accumulator: hits saturates at 2, meaning "more than one intersection" (ghost-prone).
  always_comb begin
    row_cnt    = 3'd0;
    row_idx    = 2'd0;
    hits_d     = hits_q;
    hit_code_d = hit_code_q;
    for (int r = 0; r < 4; r++) begin
      if (!rows_sync_q[r]) begin
        row_cnt = row_cnt + 3'd1;
        row_idx = 2'(r);
      end
    end
    if (row_cnt >= 3'd2 || (row_cnt == 3'd1 && hits_q != 2'd0)) begin
      hits_d = 2'd2;
    end else if (row_cnt == 3'd1) begin
      hits_d     = 2'd1;
      hit_code_d = {row_idx, col_idx_q};
    end
  end

  assign frame_key  = (hits_d == 2'd1);
  assign frame_code = hit_code_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
      scan_cnt_q  <= '0;
      col_idx_q   <= 2'd0;
      cols_q      <= 4'b1110;
      hits_q      <= 2'd0;
      hit_code_q  <= 4'd0;
    end else begin
      rows_meta_q <= rows;
      rows_sync_q <= rows_meta_q;
      scan_cnt_q  <= scan_cnt_q + 1'b1;
      if (tick) begin
        col_idx_q  <= col_idx_q + 2'd1;
        cols_q     <= {cols_q[2:0], cols_q[3]};
        hits_q     <= frame_end ? 2'd0 : hits_d;
        hit_code_q <= frame_end ? 4'd0 : hit_code_d;
      end
    end
  end

  always_comb begin
    ev = 1'b0;
    if (frame_end && frame_key && frame_code == cand_q) begin
      if (state_q == ST_CONFIRM && cnt_q >= 4'(DEBOUNCE_FRAMES - 1)) ev = 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
      if (state_q == ST_HELD && rep_cnt_q == RW'(REPEAT_FRAMES - 1)) ev = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
      rcnt_q  <= 4'd0;
      held_q  <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_cnt_q <= '0;
`endif
    end else if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_key) begin
            cand_q  <= frame_code;
            cnt_q   <= 4'd1;
            state_q <= ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (!frame_key) begin
            state_q <= ST_IDLE;
          end else if (frame_code != cand_q) begin
            cand_q <= frame_code;
            cnt_q  <= 4'd1;
          end else if (cnt_q >= 4'(DEBOUNCE_FRAMES - 1)) begin
            state_q <= ST_HELD;
            held_q  <= 1'b1;
            rcnt_q  <= 4'd0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt_q <= '0;
`endif
          end else if (cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_HELD: begin
          // A different key counts toward release exactly like no key at all.
          if (frame_key && frame_code == cand_q) begin
            rcnt_q <= 4'd0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt_q <= (rep_cnt_q == RW'(REPEAT_FRAMES - 1)) ? '0 : rep_cnt_q + 1'b1;
`endif
          end else begin
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt_q <= '0;
`endif
            if (rcnt_q >= 4'(DEBOUNCE_FRAMES - 1)) begin
              state_q <= ST_IDLE;
              held_q  <= 1'b0;
            end else if (rcnt_q != 4'hF) begin
              rcnt_q <= rcnt_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake: an edge with key_valid=1 and key_ready=1 is a transfer. key_code is frozen
  // while key_valid=1; an event arriving while an undelivered one is pending and no
  // transfer happens is dropped and sets key_overrun, which only a transfer clears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      code_q    <= 4'd0;
      overrun_q <= 1'b0;
    end else begin
      if (ev && (!valid_q || key_ready)) code_q <= cand_q;
      valid_q <= ev || (valid_q && !key_ready);
      if (valid_q && key_ready) overrun_q <= 1'b0;
      else if (ev && valid_q)   overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from cols, and a frame-level
// reference derives expected events from the history of frame results.
module tb_keypad_scanner;
  localparam int SR    = 2;
  localparam int DB    = 4;
  localparam int RP    = 2;
  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] rows, cols, key_code;
  logic       key_valid, key_held, key_overrun;
  logic       key_ready = 1'b0;
  logic [1:0] dbg_state;
  logic [15:0] mask = 16'h0;

  int total = 0;
  int bad = 0;
  int ecnt = 0;
  int ready_mode = 0;
  logic [4:0] res_q[$];
  logic [3:0] exp_q[$];
  bit         m_held, m_valid, m_ovr;
  logic [3:0] m_hcode, m_code;
  int         t_rel, t_acc;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_RATE(SR), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(RP)) dut (
    .clk(clk), .reset_n(reset_n), .rows(rows), .cols(cols), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
    .key_overrun(key_overrun), .dbg_state_o(dbg_state)
  );

  // Keypad: a pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (cols[c] == 1'b0 && mask[r*4+c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] frame_result(input logic [15:0] m);
    logic [4:0] r;
    r = 5'd16;
    if ($countones(m) == 1)
      for (int i = 0; i < 16; i++) if (m[i]) r = 5'(i);
    return r;
  endfunction

  function automatic bit window_is(input int n, input logic [4:0] v, input bit eq);
    bit ok;
    ok = 1'b1;
    for (int i = n - DB + 1; i <= n; i++)
      if ((res_q[i-1] == v) != eq) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_reset();
    ecnt = 0;
    res_q.delete();
    exp_q.delete();
    m_held = 0; m_valid = 0; m_ovr = 0;
    m_hcode = 4'd0; m_code = 4'd0;
    t_rel = 0; t_acc = 0;
  endtask

  task automatic model_frame(input logic [15:0] m, output bit ev);
    logic [4:0] r;
    int n;
    r = frame_result(m);
    res_q.push_back(r);
    n = res_q.size();
    ev = 1'b0;
    if (!m_held) begin
      if (r != 5'd16 && n - DB >= t_rel && window_is(n, r, 1'b1)) begin
        m_held = 1; m_hcode = r[3:0]; t_acc = n; ev = 1'b1;
      end
    end else if (n - DB >= t_acc && window_is(n, {1'b0, m_hcode}, 1'b0)) begin
      m_held = 0; t_rel = n;
    end
`ifdef KEYPAD_TYPEMATIC_EN
    else if (r == {1'b0, m_hcode}) begin
      int run;
      run = 0;
      for (int i = n; i > t_acc && res_q[i-1] == r; i--) run++;
      if (run % RP == 0) ev = 1'b1;
    end
`endif
  endtask

  task automatic step();
    bit   ev;
    logic xfer;
    logic [3:0] exp_cols;
    if (reset_n && key_valid === 1'b1 && key_ready)
      check("xfer_code", 8'(key_code), (exp_q.size() != 0) ? 8'(exp_q.pop_front()) : 8'hFF);
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      xfer = m_valid && key_ready;
      ecnt++;
      ev = 1'b0;
      if (ecnt % FRAME == 0) model_frame(mask, ev);
      if (ev && (!m_valid || key_ready)) begin
        m_code = m_hcode;
        exp_q.push_back(m_hcode);
      end
      if (xfer) m_ovr = 0;
      else if (ev && m_valid) m_ovr = 1;
      m_valid = ev || (m_valid && !key_ready);
    end
    #1;
    exp_cols = ~(4'b0001 << ((ecnt / 4) % 4));
    check("cols", 8'(cols), 8'(exp_cols));
    check("key_valid", 8'(key_valid), 8'(m_valid));
    check("key_code", 8'(key_code), 8'(m_code));
    check("key_held", 8'(key_held), 8'(m_held));
    check("key_overrun", 8'(key_overrun), 8'(m_ovr));
    case (ready_mode)
      0: key_ready = 1'b0;
      1: key_ready = 1'b1;
      default: key_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    key_ready = 1'b0;
    mask = 16'h0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic run_frames(input logic [15:0] m, input int nf);
    mask = m;
    for (int f = 0; f < nf; f++) begin
      step();
      while (ecnt % FRAME != 0) step();
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single press of key 9 (row 2, col 1) with a ready consumer, then release.
    ready_mode = 1;
    run_frames(16'h0200, 6);
    run_frames(16'h0000, 6);
    check("held_after_release", 8'(key_held), 8'd0);

    // Bouncing contact, then a ghost-prone two-key chord.
    run_frames(16'h0200, 1); run_frames(16'h0000, 1);
    run_frames(16'h0200, 1); run_frames(16'h0000, 3);
    run_frames(16'h0021, 10);
    check("multi_not_held", 8'(key_held), 8'd0);
    run_frames(16'h0000, 2);

    // Stalled consumer: second press is dropped, one ready pulse delivers the first.
    ready_mode = 0;
    run_frames(16'h0008, 5); run_frames(16'h0000, 5);
    run_frames(16'h1000, 5); run_frames(16'h0000, 5);
    check("overrun_set", 8'(key_overrun), 8'd1);
    key_ready = 1'b1;
    step();
    check("overrun_cleared", 8'(key_overrun), 8'd0);
    while (ecnt % FRAME != 0) step();

    // Long hold of key F (repeats appear only with auto-repeat built in).
    ready_mode = 1;
    run_frames(16'h8000, 12);
    run_frames(16'h0000, 5);

    // Reset in the middle of a debounce with an event pending.
    ready_mode = 0;
    run_frames(16'h0040, 5);
    for (int i = 0; i < 7; i++) step();
    do_reset();

    // Randomized segments of idle, single keys and chords under a random consumer.
    for (int s = 0; s < 60; s++) begin
      logic [15:0] m;
      int a, k;
      k = $urandom_range(0, 99);
      a = $urandom_range(0, 15);
      if (k < 40) m = 16'h0;
      else if (k < 85) m = 16'h1 << a;
      else m = (16'h1 << a) | (16'h1 << ((a + $urandom_range(1, 15)) % 16));
      ready_mode = ($urandom_range(0, 4) == 0) ? 0 : 2;
      run_frames(m, $urandom_range(1, 7));
    end
    ready_mode = 1;
    run_frames(16'h0000, 6);
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver: scans a 4x4 matrix keypad by driving one active-low column at a time and sampling four active-low row lines.
- Debounces each press and encodes it to a 4-bit hex key code.
- Delivers each press as one valid/ready transfer to the consuming logic, for example a memory-mapped I/O register read by the CPU.

Parameters:
- SCAN_RATE, 18, column dwell is 2^SCAN_RATE clk cycles; the scan counter is SCAN_RATE bits and wraps.
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames needed to accept a press or a release (range 2..15).
- REPEAT_FRAMES, 32, frames between auto-repeat events; used only with KEYPAD_TYPEMATIC_EN.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- rows  input  4  row sense lines, active-low (externally pulled up); asynchronous
- cols  output  4  column drive, exactly one bit low at any time
- key_code  output  4  encoded key, row_idx*4 + col_idx
- key_valid  output  1  key_code holds an undelivered event
- key_ready  input  1  consumer accepts the event when key_valid=1
- key_held  output  1  a debounced key is currently down
- key_overrun  output  1  sticky flag: an event was dropped while key_valid=1

Behaviour:
- Reset, when reset_n=0 at a clk edge:
  - cols=4'b1110, key_code=0, key_valid=0, key_held=0, key_overrun=0.
  - Scan counter, column index, frame accumulators and debounce state all cleared.
  - Reset mid-scan or mid-debounce discards everything in flight.
- Synchronizer: rows pass through a 2-flop synchronizer; only the synchronized value is used.
- Tick: asserted for one cycle when the scan counter equals all ones.
- On each tick:
  - Sample the synchronized rows for the current column.
  - Advance cols 1110 -> 1101 -> 1011 -> 0111 -> 1110, so col_idx runs 0..3.
  - The dwell covers the synchronizer delay plus line settling.
- Frame: one pass over 4 ticks; it ends on the tick that samples col_idx=3. The frame result is:
  - NONE if no row bit was low;
  - KEY(code) if exactly one row/column intersection was low across the frame;
  - MULTI if two or more were low. MULTI is treated as NONE, so no ghost-key events are produced.
- Debounce FSM, evaluated only at frame end:
  - IDLE:
    - A KEY(c) result loads cand=c, cnt=1 and moves to CONFIRM.
  - CONFIRM:
    - Same KEY(c) increments cnt.
    - Different KEY(c') reloads cand=c', cnt=1.
    - NONE or MULTI returns to IDLE.
    - When cnt reaches DEBOUNCE_FRAMES: emit event(cand), set key_held=1, go to HELD.
  - HELD:
    - Any result other than KEY(cand) increments rcnt; KEY(cand) clears rcnt.
    - When rcnt reaches DEBOUNCE_FRAMES: key_held=0, go to IDLE.
    - A different key pressed while held emits nothing until release completes.
- Latency: an event is visible (key_valid=1, key_code updated) on the cycle after the frame-end tick that completes debounce.
- Handshake:
  - A transfer occurs on any clk edge with key_valid=1 and key_ready=1.
  - key_valid falls the next cycle unless a new event lands on that same edge.
  - key_code is stable while key_valid=1.
  - key_ready while key_valid=0 has no effect.
- Simultaneous cases:
  - Event and transfer on the same edge: the new code loads, key_valid stays 1, no overrun.
  - Event while key_valid=1 with no transfer: the event is dropped, key_code is unchanged, key_overrun=1.
  - key_overrun clears only on the edge of the next transfer, or on reset.
- Counters saturate; none wrap except the scan counter.

Optional Feature:
- KEYPAD_TYPEMATIC_EN defined:
  - In HELD, a frame counter advances on every KEY(cand) frame.
  - Every REPEAT_FRAMES such frames, a repeat event with the same code is emitted through the same handshake and overrun rules.
  - The counter clears on entry to HELD and on any non-matching frame.
- Not defined: exactly one event per debounced press; no repeat logic is synthesized.

Test Plan:
- Reset with SCAN_RATE=2 -> cols=1110, key_valid=0, key_held=0, key_overrun=0. cols rotates every 4 cycles: 1101, 1011, 0111, 1110.
- Model key at row 2 / col 1 held for 6 frames, key_ready=1 -> exactly one event key_code=4'h9. key_valid is high for 1 cycle, on the cycle after frame 4 ends. key_held=1 until 4 NONE frames after release.
- Key bouncing (present in frames 1 and 3, absent in 2 and 4) -> no event, state back in IDLE.
- Keys 0x0 and 0x5 both held (MULTI) for 10 frames -> no event, key_held=0.
- key_ready=0: press 0x3, release, press 0xC -> key_code stays 3 and key_overrun=1. Raising key_ready for one cycle transfers 3 and clears key_overrun.
- With KEYPAD_TYPEMATIC_EN and REPEAT_FRAMES=2: hold 0xF for 8 frames after acceptance, key_ready=1 -> initial event plus 4 repeats, all code 4'hF.
